comp_iter: RTL and testbench
============================

// Module: comp_iter
// PURPOSE
//  Multi-cycle magnitude comparator for WIDTH-bit operands, processed MSB-first, DIGIT bits per cycle.
//  Next generation of the 1-bit gt/eq compare cell: parametrised width, signed/unsigned mode, lt output,
//  start/busy/done handshake. Sits beside the ALU as a low-area compare unit for branch/set-less-than paths.
// PARAMETERS
//  WIDTH  32  operand width in bits; must be a multiple of DIGIT
//  DIGIT  4   bits compared per cycle; N = WIDTH/DIGIT digit steps
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled only when idle (IDLE or DONE state)
//  is_signed  in   1      1 = two's-complement compare, 0 = unsigned; sampled with start
//  a          in   WIDTH  operand A, sampled with start
//  b          in   WIDTH  operand B, sampled with start
//  busy       out  1      compare in progress (RUN state)
//  done       out  1      single-cycle pulse: gt/lt/eq valid from this cycle
//  gt         out  1      A > B
//  lt         out  1      A < B
//  eq         out  1      A == B
// BEHAVIOUR
//  - Reset: busy=0, done=0, gt=0, lt=0, eq=0, state=IDLE, digit counter=0. Reset wins over start.
//  - States: IDLE -start-> RUN; RUN -digit differs (early exit) or last digit-> DONE; DONE -> IDLE,
//    or DONE -start-> RUN (back-to-back accepted). start in RUN is ignored, operands not re-latched.
//  - Latch: on accepted start, regs ra/rb <= a/b; if is_signed, MSB of both inverted (offset-binary),
//    so the digit compare is always unsigned. gt/lt/eq cleared at accept.
//  - RUN: each cycle compare top DIGIT bits of ra/rb via comp_digit; ra/rb shift left by DIGIT; counter++.
//    First differing digit sets gt or lt; all N digits equal sets eq. Exactly one of gt/lt/eq is 1 after done.
//  - Latency (start high in cycle k): busy high from k+1; first differing digit i (0 = most significant)
//    -> done high in cycle k+i+2; all equal -> done in cycle k+N+1. busy low in the done cycle.
//  - gt/lt/eq hold their value after done until the next accepted start or rst.
//  - Reset mid-RUN aborts: no done pulse, outputs zero the following cycle.
// CONFIGURATION
//  COMP_EARLY_EXIT_EN defined: RUN terminates at the first differing digit (latency above).
//  Not defined: RUN always takes N cycles, done in cycle k+N+1 regardless of data (constant-time);
//  first differing digit is recorded and later digits do not alter the result.
// STRUCTURE
//  Shared package comp_pkg.vh: state encodings (ST_IDLE, ST_RUN, ST_DONE), result encoding constants,
//  clog2 helper for counter width.
//  Sub-module comp_digit: combinational DIGIT-bit unsigned compare (outputs gt, eq), MSB-priority chain
//  of 1-bit compare cells; instantiated once in comp_iter.
// TESTING
//  1. WIDTH=8 DIGIT=1 unsigned, a=8'h80 b=8'h7F -> gt=1 lt=0 eq=0; with EN done in k+2, without in k+9.
//  2. WIDTH=8 DIGIT=1 is_signed=1, a=8'h80(-128) b=8'h7F(127) -> lt=1 gt=0 eq=0.
//  3. WIDTH=8 DIGIT=1, a=b=8'hA5 -> eq=1, done in k+9 in both configs; busy high k+1..k+8.
//  4. start a=3 b=5, then start a=9 b=1 during RUN -> ignored; result lt=1; back-to-back start in done
//     cycle accepted, busy high next cycle.
//  5. rst asserted in cycle k+3 of an all-equal compare -> busy/done/gt/lt/eq = 0 from k+4, no done pulse.
//  6. WIDTH=32 DIGIT=4, a=32'h0000_0010 b=32'h0000_0001 -> gt=1; EN done in k+8, else k+9.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared types and helpers for the iterative magnitude comparator (comp_iter, comp_digit).
// Build option: COMP_EARLY_EXIT_EN selects early termination in comp_iter.
package comp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ResNone = 2'd0,
        ResGt   = 2'd1,
        ResLt   = 2'd2,
        ResEq   = 2'd3
    } result_e;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/comp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice, built as an MSB-priority chain
// of 1-bit gt/eq cells.
module comp_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o
);

    // Chain index DIGIT is the seed above the MSB; index 0 is the final result.
    logic [DIGIT:0] gt_chain;
    logic [DIGIT:0] eq_chain;

    assign gt_chain[DIGIT] = 1'b0;
    assign eq_chain[DIGIT] = 1'b1;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign gt_chain[i] = gt_chain[i+1] | (eq_chain[i+1] & a_i[i] & ~b_i[i]);
        assign eq_chain[i] = eq_chain[i+1] & (a_i[i] ~^ b_i[i]);
    end

    assign gt_o = gt_chain[0];
    assign eq_o = eq_chain[0];

endmodule

// File: rtl/comp_iter.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed or unsigned.
// Define COMP_EARLY_EXIT_EN to stop at the first differing digit; otherwise always N cycles.
module comp_iter
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int unsigned N = WIDTH / DIGIT;
    localparam int unsigned CNT_W = clog2_min1(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    result_e          res_q, res_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic [WIDTH-1:0] a_ob, b_ob;
    logic             dig_gt, dig_eq;
    result_e          res_now, res_fin;
    logic             finish;
    logic             accept;

    // Offset-binary: flipping both sign bits makes a signed compare an unsigned one.
    always_comb begin
        a_ob = a;
        b_ob = b;
        if (is_signed) begin
            a_ob[WIDTH-1] = ~a[WIDTH-1];
            b_ob[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    comp_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_i (ra_q[WIDTH-1 -: DIGIT]),
        .b_i (rb_q[WIDTH-1 -: DIGIT]),
        .gt_o(dig_gt),
        .eq_o(dig_eq)
    );

    // The first differing digit decides; later digits cannot change a recorded result.
    always_comb begin
        res_now = res_q;
        if ((res_q == ResNone) && !dig_eq) begin
            res_now = dig_gt ? ResGt : ResLt;
        end
        res_fin = (res_now == ResNone) ? ResEq : res_now;
        finish  = (cnt_q == LAST);
`ifdef COMP_EARLY_EXIT_EN
        finish  = finish || (res_now != ResNone);
`endif
    end

    assign accept = start && (state_q != StRun);

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StRun;
                    ra_d    = a_ob;
                    rb_d    = b_ob;
                    cnt_d   = '0;
                    res_d   = ResNone;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                ra_d  = ra_q << DIGIT;
                rb_d  = rb_q << DIGIT;
                cnt_d = cnt_q + CNT_W'(1);
                res_d = res_now;
                if (finish) begin
                    state_d = StDone;
                    gt_d    = (res_fin == ResGt);
                    lt_d    = (res_fin == ResLt);
                    eq_d    = (res_fin == ResEq);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
            res_q   <= ResNone;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_comp_iter.sv
// Self-checking bench for comp_iter: an 8-bit/1-bit-digit and a 32-bit/4-bit-digit instance
// checked against a plain-arithmetic reference model; honours COMP_EARLY_EXIT_EN.
module tb_comp_iter;

`ifdef COMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, sgn8, busy8, done8, gt8, lt8, eq8;
    logic [7:0]  in_a8, in_b8;
    logic        start32, sgn32, busy32, done32, gt32, lt32, eq32;
    logic [31:0] in_a32, in_b32;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    comp_iter #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .a(in_a8), .b(in_b8),
        .busy(busy8), .done(done8), .gt(gt8), .lt(lt8), .eq(eq8)
    );

    comp_iter #(.WIDTH(32), .DIGIT(4)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32), .a(in_a32), .b(in_b32),
        .busy(busy32), .done(done32), .gt(gt32), .lt(lt32), .eq(eq32)
    );

    // Reference: {gt, lt, eq} from integer comparison of the operands.
    function automatic logic [2:0] ref_result(input bit wide, input logic [31:0] a,
                                              input logic [31:0] b, input bit sgn);
        longint av, bv;
        logic [7:0] a_n, b_n;
        a_n = a[7:0];
        b_n = b[7:0];
        if (wide) begin
            av = sgn ? longint'($signed(a)) : longint'(a);
            bv = sgn ? longint'($signed(b)) : longint'(b);
        end else begin
            av = sgn ? longint'($signed(a_n)) : longint'(a_n);
            bv = sgn ? longint'($signed(b_n)) : longint'(b_n);
        end
        return {av > bv, av < bv, av == bv};
    endfunction

    // Reference: cycles from accepted start to done (both instances have 8 digit steps).
    function automatic int ref_latency(input bit wide, input logic [31:0] a, input logic [31:0] b);
        int w;
        int dw;
        logic [31:0] x;
        logic [31:0] dig;
        w  = wide ? 32 : 8;
        dw = wide ? 4 : 1;
        x  = a ^ b;
        if (!wide) x[31:8] = '0;
        for (int i = 0; i < 8; i++) begin
            dig = (x >> (w - dw * (i + 1))) & ((32'd1 << dw) - 32'd1);
            if (dig != 0) return EARLY ? i + 2 : 9;
        end
        return 9;
    endfunction

    function automatic logic [4:0] obs(input bit wide);
        return wide ? {busy32, done32, gt32, lt32, eq32} : {busy8, done8, gt8, lt8, eq8};
    endfunction

    task automatic drive(input bit wide, input logic [31:0] a, input logic [31:0] b,
                         input bit sgn, input bit st);
        in_a32  = a;
        in_b32  = b;
        in_a8   = a[7:0];
        in_b8   = b[7:0];
        sgn32   = sgn;
        sgn8    = sgn;
        start32 = st & wide;
        start8  = st & ~wide;
    endtask

    // Presents start in cycle k and returns just after the edge that closes cycle k.
    task automatic launch(input bit wide, input logic [31:0] a, input logic [31:0] b,
                          input bit sgn);
        @(negedge clk);
        drive(wide, a, b, sgn, 1'b1);
        @(posedge clk);
    endtask

    // Samples cycles k+1.. until done; start is released from cycle k+hold. Returns -1 on timeout.
    task automatic wait_done(input bit wide, input int hold, output int cyc, output int busy_err);
        logic [4:0] o;
        cyc      = -1;
        busy_err = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            o = obs(wide);
            if (j >= hold) begin
                start8  = 1'b0;
                start32 = 1'b0;
            end
            if (o[3]) begin
                cyc = j;
                if (o[4]) busy_err++;
                return;
            end
            if (!o[4]) busy_err++;
        end
    endtask

    task automatic test_reset();
        logic [4:0] o;
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs(1'b0) !== 5'b0) $display("FAIL reset8: got %b expected 00000", obs(1'b0));
        else n_pass++;
        n_checks++;
        if (obs(1'b1) !== 5'b0) $display("FAIL reset32: got %b expected 00000", obs(1'b1));
        else n_pass++;
        drive(1'b0, 32'd1, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        o = obs(1'b0);
        n_checks++;
        if (o !== 5'b0) $display("FAIL reset_over_start: got %b expected 00000", o);
        else n_pass++;
        rst    = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        o = obs(1'b0);
        n_checks++;
        if (o !== 5'b0) $display("FAIL reset_release: got %b expected 00000", o);
        else n_pass++;
    endtask

    typedef struct {
        bit          wide;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        logic [2:0]  res;
        int          lat;
    } case_t;

    task automatic test_directed();
        case_t      tc [8];
        int         cyc, be;
        logic [4:0] o;
        tc[0] = '{1'b0, 32'h80, 32'h7F, 1'b0, 3'b100, EARLY ? 2 : 9};
        tc[1] = '{1'b0, 32'h80, 32'h7F, 1'b1, 3'b010, EARLY ? 2 : 9};
        tc[2] = '{1'b0, 32'hA5, 32'hA5, 1'b0, 3'b001, 9};
        tc[3] = '{1'b0, 32'hA5, 32'hA5, 1'b1, 3'b001, 9};
        tc[4] = '{1'b1, 32'h10, 32'h01, 1'b0, 3'b100, EARLY ? 8 : 9};
        tc[5] = '{1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 3'b010, EARLY ? 2 : 9};
        tc[6] = '{1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 3'b100, EARLY ? 2 : 9};
        tc[7] = '{1'b1, 32'h1, 32'h0, 1'b0, 3'b100, 9};
        for (int i = 0; i < 8; i++) begin
            launch(tc[i].wide, tc[i].a, tc[i].b, tc[i].sgn);
            wait_done(tc[i].wide, 1, cyc, be);
            o = obs(tc[i].wide);
            n_checks++;
            if (cyc !== tc[i].lat) $display("FAIL dir_lat[%0d]: got %0d expected %0d", i, cyc, tc[i].lat);
            else n_pass++;
            n_checks++;
            if (be !== 0) $display("FAIL dir_busy[%0d]: got %0d bad cycles expected 0", i, be);
            else n_pass++;
            n_checks++;
            if (o[2:0] !== tc[i].res) $display("FAIL dir_res[%0d]: got %b expected %b", i, o[2:0], tc[i].res);
            else n_pass++;
            @(negedge clk);
            o = obs(tc[i].wide);
            n_checks++;
            if (o !== {2'b00, tc[i].res}) $display("FAIL dir_hold[%0d]: got %b expected 00%b", i, o, tc[i].res);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int         cyc, be;
        logic [4:0] o;
        launch(1'b0, 32'd3, 32'd5, 1'b0);
        #1 drive(1'b0, 32'd9, 32'd1, 1'b0, 1'b1);
        wait_done(1'b0, 4, cyc, be);
        o = obs(1'b0);
        n_checks++;
        if (cyc !== (EARLY ? 7 : 9)) $display("FAIL ign_lat: got %0d expected %0d", cyc, EARLY ? 7 : 9);
        else n_pass++;
        n_checks++;
        if (o[2:0] !== 3'b010) $display("FAIL ign_res: got %b expected 010", o[2:0]);
        else n_pass++;
        drive(1'b0, 32'd9, 32'd1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        n_checks++;
        if (busy8 !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", busy8);
        else n_pass++;
        wait_done(1'b0, 1, cyc, be);
        o = obs(1'b0);
        n_checks++;
        if (cyc !== (EARLY ? 6 : 9)) $display("FAIL b2b_lat: got %0d expected %0d", cyc, EARLY ? 6 : 9);
        else n_pass++;
        n_checks++;
        if (o[2:0] !== 3'b100) $display("FAIL b2b_res: got %b expected 100", o[2:0]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int         pulses;
        logic [4:0] o;
        launch(1'b0, 32'hA5, 32'hA5, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b1) $display("FAIL abort_pre_busy: got %b expected 1", busy8);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        o = obs(1'b0);
        n_checks++;
        if (o !== 5'b0) $display("FAIL abort_outputs: got %b expected 00000", o);
        else n_pass++;
        rst    = 1'b0;
        pulses = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done8 !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL abort_no_done: got %0d done cycles expected 0", pulses);
        else n_pass++;
    endtask

    task automatic test_random();
        bit          wide, sgn;
        logic [31:0] a, b;
        logic [2:0]  exp_res;
        int          exp_lat, cyc, be;
        logic [4:0]  o;
        for (int i = 0; i < 60; i++) begin
            wide = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (32'd1 << $urandom_range(0, wide ? 31 : 7));
                default: b = a ^ ($urandom & 32'h0000_000F);
            endcase
            exp_res = ref_result(wide, a, b, sgn);
            exp_lat = ref_latency(wide, a, b);
            launch(wide, a, b, sgn);
            wait_done(wide, 1, cyc, be);
            o = obs(wide);
            n_checks++;
            if (cyc !== exp_lat) $display("FAIL rnd_lat[%0d]: got %0d expected %0d", i, cyc, exp_lat);
            else n_pass++;
            n_checks++;
            if (be !== 0) $display("FAIL rnd_busy[%0d]: got %0d bad cycles expected 0", i, be);
            else n_pass++;
            n_checks++;
            if (o[2:0] !== exp_res)
                $display("FAIL rnd_res[%0d]: a=%h b=%h s=%0d w=%0d got %b expected %b",
                         i, a, b, sgn, wide, o[2:0], exp_res);
            else n_pass++;
            @(negedge clk);
            o = obs(wide);
            n_checks++;
            if (o !== {2'b00, exp_res}) $display("FAIL rnd_hold[%0d]: got %b expected 00%b", i, o, exp_res);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
